mul_div_unit: RTL and testbench

//  Iterative multiply/divide unit that owns the HI/LO register pair.

---
 rtl/mdu_pkg.sv | 27 ++
 rtl/mul_div_unit_if.sv | 32 +++
 rtl/mdu_step.sv | 29 ++
 rtl/mul_div_unit.sv | 132 +++++++++++++
 tb/tb_mul_div_unit.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op/state encodings and counter-width helper for the multiply/divide unit
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } mdu_state_e;

    // Bits needed to count 0..n-1 (at least 1)
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: issue, MTHI/MTLO and result signals between EX and the multiply/divide unit
interface mul_div_unit_if
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             flush;
    logic             whi;
    logic             wlo;
    logic [WIDTH-1:0] wHiData;
    logic [WIDTH-1:0] wLoData;
    logic [WIDTH-1:0] rHiData;
    logic [WIDTH-1:0] rLoData;
    logic             busy;
    logic             done;
    logic             div0;
    logic             err_busy;

    modport master (
        output start, op, opa, opb, flush, whi, wlo, wHiData, wLoData,
        input  rHiData, rLoData, busy, done, div0, err_busy
    );

    modport slave (
        input  start, op, opa, opb, flush, whi, wlo, wHiData, wLoData,
        output rHiData, rLoData, busy, done, div0, err_busy
    );
endinterface

// File: rtl/mdu_step.sv
// mdu_step: one radix-2 step, shift-add for multiply or restoring subtract for divide
module mdu_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_div,
    input  logic [WIDTH-1:0] i_acc,
    input  logic             i_lsb,
    input  logic [WIDTH-1:0] i_opd,
    output logic [WIDTH-1:0] o_acc,
    output logic             o_qbit
);
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_top;
    logic [WIDTH-1:0] w_sub;
    logic             w_ge;

    // Multiply: add operand when multiplier LSB set, bit 0 of sum shifts into LO.
    // Divide: shift in next dividend bit, subtract divisor when it fits.
    always_comb begin
        w_sum  = {1'b0, i_acc} + (i_lsb ? {1'b0, i_opd} : '0);
        w_top  = {i_acc, i_lsb};
        w_ge   = w_top >= {1'b0, i_opd};
        w_sub  = w_top[WIDTH-1:0] - i_opd;
        o_acc  = i_div ? (w_ge ? w_sub : w_top[WIDTH-1:0]) : w_sum[WIDTH:1];
        o_qbit = i_div ? w_ge : w_sum[0];
    end
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative signed/unsigned multiply/divide owning the HI/LO register pair
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    mul_div_unit_if.slave    bus
);
    localparam int CW = clog2(WIDTH);

    mdu_state_e         r_state;
    mdu_state_e         w_next;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opd;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_div;
    logic               r_dz;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_busy;
    logic               r_done;
    logic               r_div0;
    logic               r_err;

    logic               w_accept;
    logic               w_div;
    logic               w_dz;
    logic               w_sa;
    logic               w_sb;
    logic               w_lsb;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_ma;
    logic [WIDTH-1:0]   w_mb;
    logic [WIDTH-1:0]   w_step;
    logic [WIDTH-1:0]   w_q;
    logic [WIDTH-1:0]   w_r;
    logic [2*WIDTH-1:0] w_prod;

    // Operand magnitudes on accept and sign-corrected results in FIX
    always_comb begin
        w_div    = (bus.op == MDU_DIV) || (bus.op == MDU_DIVU);
        w_sa     = ((bus.op == MDU_MULT) || (bus.op == MDU_DIV)) && bus.opa[WIDTH-1];
        w_sb     = ((bus.op == MDU_MULT) || (bus.op == MDU_DIV)) && bus.opb[WIDTH-1];
        w_ma     = w_sa ? -bus.opa : bus.opa;
        w_mb     = w_sb ? -bus.opb : bus.opb;
        w_dz     = w_div && (bus.opb == '0);
        w_accept = (r_state == IDLE) && bus.start && !bus.flush;
        w_lsb    = r_div ? r_acc[WIDTH-1] : r_acc[0];
        w_prod   = r_neg_q ? -r_acc : r_acc;
        w_q      = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_r      = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    end

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .i_div  (r_div),
        .i_acc  (r_acc[2*WIDTH-1:WIDTH]),
        .i_lsb  (w_lsb),
        .i_opd  (r_opd),
        .o_acc  (w_step),
        .o_qbit (w_qbit)
    );

    // Next state: divide-by-zero skips CALC; flush returns to IDLE from CALC or FIX
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? (w_dz ? FIX : CALC) : IDLE;
            CALC:    w_next = bus.flush ? IDLE : (r_cnt == CW'(WIDTH - 1) ? FIX : CALC);
            default: w_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Datapath, HI/LO and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_acc   <= '0;
            r_opd   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_div   <= 1'b0;
            r_dz    <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_div0  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_busy <= w_next != IDLE;
            r_done <= (r_state == FIX) && !bus.flush;
            r_div0 <= (r_state == FIX) && !bus.flush && r_dz;
            r_err  <= (r_state != IDLE) && (bus.start || bus.whi || bus.wlo);
            if (w_accept) begin
                r_cnt   <= '0;
                r_div   <= w_div;
                r_dz    <= w_dz;
                r_neg_q <= w_sa ^ w_sb;
                r_neg_r <= w_sa;
                r_opd   <= w_div ? w_mb : w_ma;
                r_acc   <= w_dz ? {bus.opa, {WIDTH{1'b1}}} :
                           w_div ? {{WIDTH{1'b0}}, w_ma} : {{WIDTH{1'b0}}, w_mb};
            end else if (r_state == CALC) begin
                r_cnt <= r_cnt + 1'b1;
                r_acc <= {w_step, r_div ? {r_acc[WIDTH-2:0], w_qbit} : {w_qbit, r_acc[WIDTH-1:1]}};
            end
            if ((r_state == IDLE) && bus.whi) r_hi <= bus.wHiData;
            if ((r_state == IDLE) && bus.wlo) r_lo <= bus.wLoData;
            if ((r_state == FIX) && !bus.flush) begin
                r_hi <= r_dz ? r_acc[2*WIDTH-1:WIDTH] : (r_div ? w_r : w_prod[2*WIDTH-1:WIDTH]);
                r_lo <= r_dz ? r_acc[WIDTH-1:0] : (r_div ? w_q : w_prod[WIDTH-1:0]);
            end
        end
    end

    assign bus.rHiData  = r_hi;
    assign bus.rLoData  = r_lo;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.div0     = r_div0;
    assign bus.err_busy = r_err;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: scoreboard bench for mul_div_unit with directed and random ops
module tb_mul_div_unit;
    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_err = 0;
    int   lat;
    int   bcnt;
    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    mul_div_unit_if #(.WIDTH(W)) bus ();

    mul_div_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the architectural rules
    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        int          sa;
        int          sb;
        longint      ps;
        logic [63:0] pu;
        sa = a;
        sb = b;
        e.dz = 1'b0;
        case (op)
            2'd0: begin
                ps = longint'(sa) * longint'(sb);
                {e.hi, e.lo} = ps;
            end
            2'd1: begin
                pu = {32'b0, a} * {32'b0, b};
                {e.hi, e.lo} = pu;
            end
            default: begin
                if (b == 0) begin
                    e.hi = a;
                    e.lo = '1;
                    e.dz = 1'b1;
                end else if (op == 2'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.hi = '0;
                    e.lo = a;
                end else if (op == 2'd2) begin
                    e.lo = sa / sb;
                    e.hi = sa % sb;
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && bus.done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no done");
            end else begin
                mon_e = exp_q.pop_front();
                check("result_hi", 64'(bus.rHiData), 64'(mon_e.hi));
                check("result_lo", 64'(bus.rLoData), 64'(mon_e.lo));
                check("result_div0", 64'(bus.div0), 64'(mon_e.dz));
                check("busy_with_done", 64'(bus.busy), 64'd0);
            end
        end
    end

    // Pulse start for one edge; returns at the negedge in cycle 1 after the start edge
    task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.opa   = a;
        bus.opb   = b;
        if (push) exp_q.push_back(model(op, a, b));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Counts cycles from cycle 1 until done, with a bound
    task automatic wait_done();
        lat  = 1;
        bcnt = 0;
        while (!bus.done && lat < 200) begin
            if (bus.busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        if (!bus.done) begin
            n_checks++;
            n_err++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", lat);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] v;
        int           sel;
        bus.start   = 1'b0;
        bus.op      = 2'd0;
        bus.opa     = '0;
        bus.opb     = '0;
        bus.flush   = 1'b0;
        bus.whi     = 1'b0;
        bus.wlo     = 1'b0;
        bus.wHiData = '0;
        bus.wLoData = '0;
        repeat (3) @(negedge clk);
        check("reset_hi", 64'(bus.rHiData), 64'd0);
        check("reset_lo", 64'(bus.rLoData), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_err", 64'(bus.err_busy), 64'd0);
        rst = 1'b0;

        launch(2'd0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
        wait_done();
        check("mult_latency", 64'(lat), 64'd34);

        launch(2'd1, 32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
        wait_done();
        check("multu_busy_cycles", 64'(bcnt), 64'd33);

        launch(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
        wait_done();
        launch(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done();

        launch(2'd3, 32'h0000_0064, 32'h0000_0000, 1'b1);
        wait_done();
        check("div0_latency", 64'(lat), 64'd2);
        check("div0_busy_cycles", 64'(bcnt), 64'd1);

        launch(2'd0, 32'd3, 32'd5, 1'b1);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.opa   = 32'd100;
        @(negedge clk);
        bus.start = 1'b0;
        check("err_busy_pulse", 64'(bus.err_busy), 64'd1);
        @(negedge clk);
        check("err_busy_one_cycle", 64'(bus.err_busy), 64'd0);
        wait_done();

        @(negedge clk);
        bus.whi     = 1'b1;
        bus.wHiData = 32'h0000_1234;
        @(negedge clk);
        bus.whi = 1'b0;
        check("mthi_idle", 64'(bus.rHiData), 64'h1234);
        launch(2'd0, 32'h1111_1111, 32'h2222_2222, 1'b0);
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_busy", 64'(bus.busy), 64'd0);
        repeat (40) @(negedge clk);
        check("flush_hi_kept", 64'(bus.rHiData), 64'h1234);

        @(negedge clk);
        bus.start   = 1'b1;
        bus.flush   = 1'b1;
        bus.whi     = 1'b1;
        bus.wHiData = 32'h0000_0055;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.whi   = 1'b0;
        check("flush_start_dropped", 64'(bus.busy), 64'd0);
        check("flush_allows_mthi", 64'(bus.rHiData), 64'h55);

        @(negedge clk);
        bus.start   = 1'b1;
        bus.op      = 2'd1;
        bus.opa     = 32'd2;
        bus.opb     = 32'd3;
        bus.whi     = 1'b1;
        bus.wHiData = 32'h0000_ABCD;
        exp_q.push_back(model(2'd1, 32'd2, 32'd3));
        @(negedge clk);
        bus.start = 1'b0;
        bus.whi   = 1'b0;
        check("mthi_with_start", 64'(bus.rHiData), 64'hABCD);
        wait_done();

        @(negedge clk);
        bus.whi     = 1'b1;
        bus.wHiData = 32'h0000_0077;
        @(negedge clk);
        bus.whi = 1'b0;
        launch(2'd1, 32'h0001_0000, 32'h0001_0000, 1'b0);
        repeat (32) @(negedge clk);
        check("fix_busy", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_hi", 64'(bus.rHiData), 64'd0);
        check("rst_mid_lo", 64'(bus.rLoData), 64'd0);
        check("rst_mid_busy", 64'(bus.busy), 64'd0);
        check("rst_mid_done", 64'(bus.done), 64'd0);
        repeat (40) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            op  = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 7);
            a   = $urandom;
            b   = $urandom;
            if (sel == 0) b = '0;
            if (sel == 1) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            if (sel == 2) begin
                a = 32'($urandom_range(0, 50)) - 32'd25;
                b = 32'($urandom_range(1, 9));
            end
            launch(op, a, b, 1'b1);
            wait_done();
            check("rand_latency", 64'(lat), (op[1] && b == 0) ? 64'd2 : 64'd34);
            if (sel == 3) begin
                v = $urandom;
                @(negedge clk);
                bus.wlo     = 1'b1;
                bus.wLoData = v;
                @(negedge clk);
                bus.wlo = 1'b0;
                check("mtlo_idle", 64'(bus.rLoData), 64'(v));
            end
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
